// File: rtl/clk_divider_pkg.sv
// rtl/clk_divider_pkg.sv - shared sizing helper for the clock divider
package clk_divider_pkg;

    // Phase counter width: max(1, clog2(div)).
    function automatic int cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - integer clock divider, clk_out low for L cycles then high for H cycles
module clk_divider
    import clk_divider_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk_in,
    input  logic rst,
    output logic clk_out
);

    localparam int W = cnt_width(DIV);
    localparam int H = DIV / 2;
    localparam int L = DIV - H;
    localparam logic [W-1:0] LAST    = W'(DIV - 1);
    localparam logic [W-1:0] LOW_LEN = W'(L);
    localparam logic [W-1:0] ONE     = W'(1);

    generate
        if (DIV < 2) begin : g_bad_div
            $fatal(1, "clk_divider: DIV must be >= 2, got DIV=%0d", DIV);
        end
    endgenerate

    // Power-up values keep clk_out defined even if no reset edge is ever seen.
    logic [W-1:0] cnt = '0;
    logic [W-1:0] cnt_next;
    logic         out_q = 1'b0;

    always_comb begin
        cnt_next = (cnt == LAST) ? '0 : cnt + ONE;
    end

    // Odd DIV puts the extra cycle in the low phase since the compare uses L.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt   <= '0;
            out_q <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            out_q <= (cnt_next >= LOW_LEN);
        end
    end

    assign clk_out = out_q;

endmodule

// File: tb/tb_clk_divider.sv
// tb/tb_clk_divider.sv - scoreboard bench for clk_divider over several DIV values
module tb_clk_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_none = 1'b0;
    logic o2, o3, o4, o5, o7, on;

    always #5 clk = ~clk;

    clk_divider #(.DIV(2)) u2 (.clk_in(clk), .rst(rst),      .clk_out(o2));
    clk_divider #(.DIV(3)) u3 (.clk_in(clk), .rst(rst),      .clk_out(o3));
    clk_divider #(.DIV(4)) u4 (.clk_in(clk), .rst(rst),      .clk_out(o4));
    clk_divider #(.DIV(5)) u5 (.clk_in(clk), .rst(rst),      .clk_out(o5));
    clk_divider #(.DIV(7)) u7 (.clk_in(clk), .rst(rst),      .clk_out(o7));
    clk_divider #(.DIV(4)) un (.clk_in(clk), .rst(rst_none), .clk_out(on));

    typedef struct packed {
        logic d2, d3, d4, d5, d7, dn;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   e  = 0;   // edges since the last reset edge (0 = in reset)
    int   en = 0;   // edges since time zero for the never-reset instance

    // Within each period of DIV edges, edge numbers L..DIV-1 are high; edge DIV ends the period low.
    function automatic logic model(input int div, input int edges);
        int pos;
        if (edges == 0) return 1'b0;
        pos = ((edges - 1) % div) + 1;
        return (pos >= (div - div / 2)) && (pos < div);
    endfunction

    task automatic drive(input logic r);
        exp_t x;
        rst = r;
        e   = r ? 0 : e + 1;
        en  = en + 1;
        x.d2 = model(2, e);
        x.d3 = model(3, e);
        x.d4 = model(4, e);
        x.d5 = model(5, e);
        x.d7 = model(7, e);
        x.dn = model(4, en);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, en, act, req);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                cmp("div2", o2, x.d2);
                cmp("div3", o3, x.d3);
                cmp("div4", o4, x.d4);
                cmp("div5", o5, x.d5);
                cmp("div7", o7, x.d7);
                cmp("div4_noreset", on, x.dn);
            end
        end
    end

    initial begin : stimulus
        int guard;
        // rst high for the first edge, then a long clean run
        drive(1'b1);
        for (int i = 0; i < 45; i++) drive(1'b0);
        // held reset
        for (int i = 0; i < 4; i++) drive(1'b1);
        for (int i = 0; i < 12; i++) drive(1'b0);
        // one-cycle reset pulses landing while the DIV=4 output is high
        for (int k = 0; k < 6; k++) begin
            guard = 0;
            while (!model(4, e) && guard < 20) begin
                drive(1'b0);
                guard++;
            end
            drive(1'b1);
            for (int i = 0; i < 3 + k; i++) drive(1'b0);
        end
        // random reset activity
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 10; i++) drive(1'b0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_divider.md
CLK_DIVIDER -- requirements
Module: clk_divider

Interface
REQ-001 SHALL have parameter DIV, default 4: integer division ratio of clk_out relative to clk_in.
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port clk_out, output, 1 bit: divided clock at f(clk_in)/DIV, driven directly from a register.
REQ-005 SHALL reject DIV < 2 at elaboration with a fatal error naming the offending value.

Function
REQ-006 SHALL keep a phase counter cnt of width max(1, clog2(DIV)), range 0..DIV-1.
REQ-007 SHALL update cnt on every clk_in rising edge with rst=0: cnt <= (cnt == DIV-1) ? 0 : cnt+1.
REQ-008 SHALL define phase lengths H = floor(DIV/2) (high) and L = DIV - H (low), so the odd-DIV extra cycle goes to the low phase.
REQ-009 SHALL register clk_out <= (cnt_next >= L), where cnt_next is the value cnt takes on that edge.
- Result: clk_out is low for L cycles, then high for H cycles, period exactly DIV clk_in cycles.
REQ-010 SHALL, counting edges from the first rising edge with rst=0 as edge 1, make clk_out rise at edge L and fall at edge DIV, then repeat every DIV edges.
REQ-011 SHALL produce no glitches: clk_out changes only at clk_in rising edges, from a flop output, with no combinational path from clk_in or rst.
REQ-012 SHALL wrap cnt from DIV-1 to 0 without a skipped or repeated state; clk_out falls on that same edge.
REQ-013 SHALL give 50% duty for even DIV; for odd DIV, duty is H/DIV (e.g. DIV=5 gives 2 high, 3 low).

Reset
REQ-014 SHALL, on any rising edge with rst=1, set cnt=0 and clk_out=0, overriding the count.
REQ-015 SHALL, on reset asserted mid-period (including while clk_out is high), drive clk_out low at that edge and restart the sequence from edge 1 after release.
REQ-016 SHALL declare power-up/initial values cnt=0 and clk_out=0, so the output is defined even if rst is deasserted before the first clk_in edge.
REQ-017 SHALL hold cnt=0 and clk_out=0 for as long as rst stays high.

Structure
REQ-018 SHALL be a single flat module with no sub-modules: one counter process and one output register.
REQ-019 SHALL compute all derived constants (counter width, H, L) as localparams inside the module; no shared package is required.
REQ-020 SHALL route clk_out to general logic only; feeding it to clock networks is the integrator's responsibility.

Verification
REQ-021 DIV=4, 1 kHz clk_in, rst high for the first edge then low -> clk_out is 250 Hz: low for edges 1, high from edge 2, low from edge 4, 10 full periods within 40 ms.
REQ-022 DIV=4, rst released before the first clk_in edge (no synchronous reset sampled) -> clk_out is never X and toggles as in REQ-021 (checks REQ-016).
REQ-023 DIV=5 -> period 5 cycles, high exactly 2 cycles, low exactly 3; rising edge at edge 3, falling edge at edge 5.
REQ-024 DIV=4, rst pulsed for one cycle while clk_out=1 -> clk_out=0 at that edge; next rise exactly 2 edges after release.
REQ-025 DIV=2 -> clk_out toggles every clk_in rising edge, rising at edge 1 after reset release.
REQ-026 DIV=1 -> elaboration fails with an error message.
